time_retry_lock_mc: RTL and testbench
=====================================

// Module: time_retry_lock_mc
// PURPOSE
// - Multi-channel retry/lock front end for time-redundant (DMR/TMR) datapaths; sits between upstream issue and the redundant unit.
// - Tags each accepted item with an ID, keeps it in a replay table until completed, reissues it on a retry request with priority.
// - After a retry, locks new input to the faulting opgroup for LockTimeout quiet cycles; adds per-ID retry limit and fault report.
// PARAMETERS
// - DataWidth     32  payload width
// - NumOpgroups   3   number of operation groups (channels)
// - OpgroupWidth  2   width of operation field, >= $clog2(NumOpgroups)
// - IDSize        5   ID width; replay table depth = 2**IDSize
// - LockTimeout   5   quiet cycles before lock release; 0 disables locking
// - MaxRetries    2   reissues allowed per ID before fault; 0 = report fault on first retry
// PORTS
// - clk_i          in   1             clock
// - rst_ni         in   1             asynchronous reset, active low
// - data_i         in   DataWidth     upstream payload
// - operation_i    in   OpgroupWidth  upstream opgroup
// - valid_i        in   1             upstream valid
// - ready_o        out  1             upstream ready
// - data_o         out  DataWidth     issued payload
// - operation_o    out  OpgroupWidth  issued opgroup
// - id_o           out  IDSize        issued ID
// - valid_o        out  1             issue valid
// - ready_i        in   1             issue ready
// - retry_valid_i  in   1             retry request from checker
// - retry_id_i     in   IDSize        ID to retry
// - retry_ready_o  out  1             retry request accepted
// - done_valid_i   in   1             completion (always accepted)
// - done_id_i      in   IDSize        ID completed
// - lock_o         out  1             lock active
// - lock_op_o      out  OpgroupWidth  opgroup input is locked to
// - fault_o        out  1             one-cycle pulse: retry limit exceeded
// - fault_id_o     out  IDSize        ID dropped by fault_o
// BEHAVIOUR
// - Reset (async, any time, aborts in-flight replay): table valid bits 0, wr_ptr 0, retry holder empty, lock 0, counts 0; all outputs 0 except retry_ready_o=1.
// - Issue mux, zero latency: if holder full -> data/op/id of held entry, valid_o=1; else pass-through data_i/operation_i, id_o=wr_ptr, valid_o=valid_i&&accept.
// - accept = !holder_full && !table_valid[wr_ptr] && (!lock || operation_i==lock_op); ready_o = ready_i && accept.
// - New handshake: table[wr_ptr]<={data,op}, valid<=1, rcnt<=0, wr_ptr<=wr_ptr+1 (wraps mod 2**IDSize). Slot at wr_ptr still valid -> stall (table full), no overwrite.
// - Holder handshake (valid_o&&ready_i): holder cleared; entry stays valid in table.
// - retry_ready_o = !holder_full. On retry accept for id r:
//   - table_valid[r]==0 or done_valid_i&&done_id_i==r same cycle -> request dropped, no state change.
//   - rcnt[r]==MaxRetries -> entry freed, fault_o=1 and fault_id_o=r next cycle, no reissue, lock untouched.
//   - else rcnt[r]++, holder<=r, lock<=1 (LockTimeout>0), lock_op<=op[r], lock counter<=LockTimeout.
// - Lock counter decrements each cycle lock=1 with no accepted retry; at reaching 0 lock<=0. New retry on other opgroup moves lock_op, reloads counter.
// - done_valid_i frees done_id_i (valid<=0); done on invalid ID ignored. Retried items may complete out of order.
// - Retried item keeps its ID; issue order of one opgroup is not guaranteed after retry, tags/IDs carry identity.
// - Held replay outranks new input; upstream ready_o=0 while holder full.
// TESTING
// - No faults, 200 random items over 3 opgroups, done after 4 cycles -> every item issued once, IDs 0..31 wrap, fault_o never 1.
// - Hold done for 32 items -> 33rd item sees ready_o=0 until done_id_i=0, then accepted with id_o=0.
// - Retry id 3 (op 1) -> next cycle valid_o=1,id_o=3, lock_o=1, lock_op_o=1; op 0 input stalls, op 1 accepted; lock_o drops exactly 5 quiet cycles later.
// - Retry id 7 three times with MaxRetries=2 -> two reissues, third gives fault_o pulse with fault_id_o=7, entry freed, no third issue.
// - done_id_i=9 and retry_id_i=9 same cycle -> retry dropped, no reissue, entry 9 free; retry on never-issued ID -> ignored.
// - Assert rst_ni mid-replay with holder full and lock active -> valid_o, lock_o, fault_o 0 immediately; after release first item gets id_o=0.

Source files
------------

// File: rtl/time_retry_lock_mc.sv
// time_retry_lock_mc: retry/lock front end for time-redundant (DMR/TMR) datapaths.
// Tags each accepted item with an ID and keeps it in a replay table until it completes.
// A retry request re-issues the stored item ahead of new input. After a retry, new
// input is locked to the faulting opgroup until LockTimeout quiet cycles have passed.
// Each ID may be reissued MaxRetries times; the next retry drops the entry and
// pulses fault_o.
//
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   data_i, operation_i, valid_i/ready_o upstream issue interface
//   data_o, operation_o, id_o, valid_o/ready_i
//                                        downstream issue interface (tagged)
//   retry_valid_i, retry_id_i, retry_ready_o
//                                        retry request from the checker
//   done_valid_i, done_id_i              completion; it is always accepted
//   lock_o, lock_op_o                    lock state and the opgroup it admits
//   fault_o, fault_id_o                  one-cycle pulse when an ID exceeds its retry limit
module time_retry_lock_mc #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumOpgroups  = 3,
  parameter int unsigned OpgroupWidth = 2,
  parameter int unsigned IDSize       = 5,
  parameter int unsigned LockTimeout  = 5,
  parameter int unsigned MaxRetries   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DataWidth-1:0]    data_i,
  input  logic [OpgroupWidth-1:0] operation_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [DataWidth-1:0]    data_o,
  output logic [OpgroupWidth-1:0] operation_o,
  output logic [IDSize-1:0]       id_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  input  logic                    retry_valid_i,
  input  logic [IDSize-1:0]       retry_id_i,
  output logic                    retry_ready_o,
  input  logic                    done_valid_i,
  input  logic [IDSize-1:0]       done_id_i,
  output logic                    lock_o,
  output logic [OpgroupWidth-1:0] lock_op_o,
  output logic                    fault_o,
  output logic [IDSize-1:0]       fault_id_o
);

  localparam int unsigned DEPTH  = 2 ** IDSize;
  localparam int unsigned RCNT_W = (MaxRetries < 2) ? 1 : $clog2(MaxRetries + 1);
  localparam int unsigned LCNT_W = (LockTimeout < 2) ? 1 : $clog2(LockTimeout + 1);

  // Reject an opgroup field that cannot encode every channel.
  if (NumOpgroups > 1 && OpgroupWidth < $clog2(NumOpgroups)) begin : g_bad_cfg
    $error("OpgroupWidth too small for NumOpgroups");
  end

  // Replay table
  logic [DataWidth-1:0]    tbl_data [DEPTH];
  logic [OpgroupWidth-1:0] tbl_op   [DEPTH];
  logic [DEPTH-1:0]        tbl_valid;
  logic [RCNT_W-1:0]       rcnt     [DEPTH];
  logic [IDSize-1:0]       wr_ptr;

  // Retry holder, lock state and registered fault outputs
  logic                    holder_full;
  logic [IDSize-1:0]       holder_id;
  logic                    lock_q;
  logic [OpgroupWidth-1:0] lock_op_q;
  logic [LCNT_W-1:0]       lock_cnt;
  logic                    fault_q;
  logic [IDSize-1:0]       fault_id_q;

  logic accept;
  logic new_hs;
  logic hold_hs;
  logic retry_hs;
  logic retry_live;
  logic retry_fault;
  logic retry_reissue;

  // Handshake and retry decode
  always_comb begin
    accept        = 1'b0;
    new_hs        = 1'b0;
    hold_hs       = 1'b0;
    retry_hs      = 1'b0;
    retry_live    = 1'b0;
    retry_fault   = 1'b0;
    retry_reissue = 1'b0;

    accept   = !holder_full && !tbl_valid[wr_ptr] && (!lock_q || operation_i == lock_op_q);
    new_hs   = valid_i && accept && ready_i;
    hold_hs  = holder_full && ready_i;
    retry_hs = retry_valid_i && !holder_full;
    // A retry that races its own completion, or names a free slot, is dropped.
    retry_live    = retry_hs && tbl_valid[retry_id_i] &&
                    !(done_valid_i && done_id_i == retry_id_i);
    retry_fault   = retry_live && (rcnt[retry_id_i] == RCNT_W'(MaxRetries));
    retry_reissue = retry_live && !retry_fault;
  end

  // Issue mux: a held replay outranks new input. Outputs read 0 while in reset.
  always_comb begin
    data_o        = '0;
    operation_o   = '0;
    id_o          = '0;
    valid_o       = 1'b0;
    ready_o       = 1'b0;
    retry_ready_o = !holder_full;
    if (rst_ni) begin
      if (holder_full) begin
        data_o      = tbl_data[holder_id];
        operation_o = tbl_op[holder_id];
        id_o        = holder_id;
        valid_o     = 1'b1;
      end else begin
        data_o      = data_i;
        operation_o = operation_i;
        id_o        = wr_ptr;
        valid_o     = valid_i && accept;
      end
      ready_o = ready_i && accept;
    end
  end

  // Payload storage; only ever read through a valid slot, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (new_hs) begin
      tbl_data[wr_ptr] <= data_i;
      tbl_op[wr_ptr]   <= operation_i;
    end
  end

  // Table bookkeeping, holder, lock timer and fault pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_valid   <= '0;
      for (int i = 0; i < DEPTH; i++) rcnt[i] <= '0;
      wr_ptr      <= '0;
      holder_full <= 1'b0;
      holder_id   <= '0;
      lock_q      <= 1'b0;
      lock_op_q   <= '0;
      lock_cnt    <= '0;
      fault_q     <= 1'b0;
      fault_id_q  <= '0;
    end else begin
      fault_q <= 1'b0;

      if (done_valid_i && tbl_valid[done_id_i]) tbl_valid[done_id_i] <= 1'b0;

      // New writes only target a free slot, so they never collide with the done above.
      if (new_hs) begin
        tbl_valid[wr_ptr] <= 1'b1;
        rcnt[wr_ptr]      <= '0;
        wr_ptr            <= wr_ptr + IDSize'(1);
      end

      if (hold_hs) holder_full <= 1'b0;

      if (retry_fault) begin
        tbl_valid[retry_id_i] <= 1'b0;
        fault_q               <= 1'b1;
        fault_id_q            <= retry_id_i;
      end

      if (retry_reissue) begin
        rcnt[retry_id_i] <= rcnt[retry_id_i] + RCNT_W'(1);
        holder_full      <= 1'b1;
        holder_id        <= retry_id_i;
      end

      // Any accepted retry counts as activity and freezes the timer; only a reissue reloads it.
      if (retry_reissue && LockTimeout > 0) begin
        lock_q    <= 1'b1;
        lock_op_q <= tbl_op[retry_id_i];
        lock_cnt  <= LCNT_W'(LockTimeout);
      end else if (lock_q && !retry_hs) begin
        if (lock_cnt <= LCNT_W'(1)) begin
          lock_q   <= 1'b0;
          lock_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt - LCNT_W'(1);
        end
      end
    end
  end

  assign lock_o     = lock_q;
  assign lock_op_o  = lock_op_q;
  assign fault_o    = fault_q;
  assign fault_id_o = fault_id_q;

endmodule

// File: tb/tb_time_retry_lock_mc.sv
// Bench for time_retry_lock_mc: directed scenarios plus randomized traffic,
// compared each cycle against a behavioural model of the retry/lock rules.
module tb_time_retry_lock_mc;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 2;
  localparam int unsigned IW = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned LT = 5;
  localparam int unsigned MR = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [DW-1:0] data_i;
  logic [OW-1:0] operation_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic [OW-1:0] operation_o;
  logic [IW-1:0] id_o;
  logic          valid_o;
  logic          ready_i;
  logic          retry_valid_i;
  logic [IW-1:0] retry_id_i;
  logic          retry_ready_o;
  logic          done_valid_i;
  logic [IW-1:0] done_id_i;
  logic          lock_o;
  logic [OW-1:0] lock_op_o;
  logic          fault_o;
  logic [IW-1:0] fault_id_o;

  time_retry_lock_mc #(
    .DataWidth(DW), .NumOpgroups(3), .OpgroupWidth(OW),
    .IDSize(IW), .LockTimeout(LT), .MaxRetries(MR)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .data_i(data_i), .operation_i(operation_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .operation_o(operation_o), .id_o(id_o), .valid_o(valid_o),
    .ready_i(ready_i),
    .retry_valid_i(retry_valid_i), .retry_id_i(retry_id_i), .retry_ready_o(retry_ready_o),
    .done_valid_i(done_valid_i), .done_id_i(done_id_i),
    .lock_o(lock_o), .lock_op_o(lock_op_o), .fault_o(fault_o), .fault_id_o(fault_id_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference ----------------
  bit            m_busy [DEPTH];   // item outstanding in the replay table
  logic [DW-1:0] m_data [DEPTH];
  logic [OW-1:0] m_op   [DEPTH];
  int            m_tries[DEPTH];   // reissues so far
  int            m_next;           // next ID handed to new input
  int            m_replay_q[$];    // pending replay (at most one)
  bit            m_locked;
  logic [OW-1:0] m_lock_op;
  int            m_quiet_left;
  bit            m_fault;
  int            m_fault_id;
  bit            m_last_new;
  int            m_last_new_id;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 0; m_tries[i] = 0; m_data[i] = '0; m_op[i] = '0;
    end
    m_next = 0; m_replay_q = {}; m_locked = 0; m_lock_op = '0;
    m_quiet_left = 0; m_fault = 0; m_fault_id = 0; m_last_new = 0;
  endtask

  function automatic bit model_accept();
    return m_replay_q.size() == 0 && !m_busy[m_next] &&
           (!m_locked || operation_i == m_lock_op);
  endfunction

  // Compare all visible outputs against the model for the current inputs.
  task automatic compare_outputs();
    bit acc;
    acc = model_accept();
    check("retry_ready_o", retry_ready_o, m_replay_q.size() == 0);
    check("ready_o", ready_o, ready_i && acc);
    check("lock_o", lock_o, m_locked);
    if (m_locked) check("lock_op_o", lock_op_o, m_lock_op);
    check("fault_o", fault_o, m_fault);
    if (m_fault) check("fault_id_o", fault_id_o, m_fault_id);
    if (m_replay_q.size() != 0) begin
      check("valid_o(replay)", valid_o, 1);
      check("id_o(replay)", id_o, m_replay_q[0]);
      check("data_o(replay)", data_o, m_data[m_replay_q[0]]);
      check("operation_o(replay)", operation_o, m_op[m_replay_q[0]]);
    end else begin
      check("valid_o", valid_o, valid_i && acc);
      if (valid_i && acc) begin
        check("id_o", id_o, m_next);
        check("data_o", data_o, data_i);
        check("operation_o", operation_o, operation_i);
      end
    end
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    bit acc, replaying, retry_taken, was_busy;
    int r;
    acc         = model_accept();
    replaying   = m_replay_q.size() != 0;
    retry_taken = retry_valid_i && !replaying;
    r           = int'(retry_id_i);
    was_busy    = m_busy[r];
    m_fault     = 0;
    m_last_new  = 0;

    if (done_valid_i) m_busy[done_id_i] = 0;
    if (!replaying && valid_i && acc && ready_i) begin
      m_busy[m_next] = 1; m_data[m_next] = data_i; m_op[m_next] = operation_i;
      m_tries[m_next] = 0; m_last_new = 1; m_last_new_id = m_next;
      m_next = (m_next + 1) % DEPTH;
    end
    if (replaying && ready_i) void'(m_replay_q.pop_front());

    if (retry_taken && was_busy && !(done_valid_i && int'(done_id_i) == r)) begin
      if (m_tries[r] >= MR) begin
        m_busy[r] = 0; m_fault = 1; m_fault_id = r;
        if (m_locked) ; // a faulting retry leaves the lock as it is
      end else begin
        m_tries[r]++;
        m_replay_q.push_back(r);
        m_locked = 1; m_lock_op = m_op[r]; m_quiet_left = LT;
        return;
      end
    end
    if (m_locked && !retry_taken) begin
      m_quiet_left--;
      if (m_quiet_left == 0) m_locked = 0;
    end
  endtask

  // ---------------- cycle helpers ----------------
  int lock_high_cnt = 0;
  int id7_issues = 0;
  int new_issues = 0;

  task automatic at_neg();
    @(negedge clk_i);
    compare_outputs();
    if (lock_o) lock_high_cnt++;
    if (valid_o && ready_i && id_o == 7 && !valid_i) id7_issues++;
    if (valid_o && ready_i && m_replay_q.size() == 0) new_issues++;
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic tick();
    at_neg();
    finish_cycle();
  endtask

  task automatic idle_inputs();
    valid_i = 0; ready_i = 1; data_i = '0; operation_i = '0;
    retry_valid_i = 0; retry_id_i = '0; done_valid_i = 0; done_id_i = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_ni = 0;
    #1;
    check("rst_valid_o", valid_o, 0);
    check("rst_lock_o", lock_o, 0);
    check("rst_fault_o", fault_o, 0);
    check("rst_retry_ready_o", retry_ready_o, 1);
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    rst_ni = 1;
  endtask

  task automatic push_item(input logic [OW-1:0] op);
    valid_i = 1; ready_i = 1; operation_i = op; data_i = $urandom;
    tick();
    valid_i = 0;
  endtask

  typedef struct { int id; int t; } pend_t;
  pend_t pend_q[$];

  initial begin
    idle_inputs();
    rst_ni = 1;
    model_reset();
    #2;
    reset_dut();

    // Clean traffic: 200 items, completion 4 cycles after issue, no retries.
    begin
      int accepted = 0;
      int budget = 0;
      new_issues = 0;
      while (accepted < 200 && budget < 5000) begin
        valid_i = ($urandom_range(3, 0) != 0);
        ready_i = ($urandom_range(3, 0) != 0);
        operation_i = OW'($urandom_range(2, 0));
        data_i = $urandom;
        done_valid_i = 0;
        if (pend_q.size() != 0 && cyc - pend_q[0].t >= 4) begin
          done_valid_i = 1; done_id_i = IW'(pend_q[0].id);
          void'(pend_q.pop_front());
        end
        tick();
        if (m_last_new) begin
          pend_q.push_back('{id: m_last_new_id, t: cyc});
          accepted++;
        end
        budget++;
      end
      if (accepted < 200) check("s1_timeout", 0, 1);
      valid_i = 0;
      while (pend_q.size() != 0 && budget < 6000) begin
        done_valid_i = 1; done_id_i = IW'(pend_q[0].id);
        void'(pend_q.pop_front());
        tick();
        budget++;
      end
      done_valid_i = 0;
      tick();
      check("s1_issued", new_issues, 200);
      check("s1_wr_ptr_wrap", dut.id_o, 200 % DEPTH);
    end

    // Table full: 33rd item waits for ID 0 to complete.
    reset_dut();
    for (int i = 0; i < 32; i++) push_item(OW'(i % 3));
    valid_i = 1; operation_i = 0; data_i = 32'hCAFE_0033;
    repeat (3) tick();
    done_valid_i = 1; done_id_i = 0;
    tick();
    done_valid_i = 0;
    at_neg();
    check("s3_ready", ready_o, 1);
    check("s3_id", id_o, 0);
    finish_cycle();
    valid_i = 0;
    tick();

    // Retry of ID 3 locks input to opgroup 1 for five quiet cycles.
    reset_dut();
    push_item(0); push_item(0); push_item(0); push_item(1);
    retry_valid_i = 1; retry_id_i = 3;
    tick();
    retry_valid_i = 0;
    lock_high_cnt = 0;
    at_neg();
    check("s4_valid", valid_o, 1);
    check("s4_id", id_o, 3);
    check("s4_lock", lock_o, 1);
    check("s4_lock_op", lock_op_o, 1);
    finish_cycle();
    valid_i = 1; operation_i = 0; data_i = 32'h0BAD;
    at_neg();
    check("s4_op0_stall", ready_o, 0);
    finish_cycle();
    operation_i = 1; data_i = 32'h600D;
    at_neg();
    check("s4_op1_accept", ready_o, 1);
    finish_cycle();
    valid_i = 0;
    repeat (5) tick();
    check("s4_lock_cycles", lock_high_cnt, 5);

    // Retry limit: third retry of ID 7 faults instead of reissuing.
    reset_dut();
    for (int i = 0; i < 8; i++) push_item(OW'(i % 3));
    id7_issues = 0;
    for (int k = 0; k < 3; k++) begin
      retry_valid_i = 1; retry_id_i = 7;
      tick();
      retry_valid_i = 0;
      if (k < 2) tick();
    end
    at_neg();
    check("s5_fault", fault_o, 1);
    check("s5_fault_id", fault_id_o, 7);
    check("s5_no_issue", valid_o, 0);
    finish_cycle();
    repeat (LT + 2) tick();
    check("s5_reissues", id7_issues, 2);

    // Retry racing its own completion, and retry of a never-issued ID.
    reset_dut();
    for (int i = 0; i < 10; i++) push_item(OW'(i % 3));
    done_valid_i = 1; done_id_i = 9; retry_valid_i = 1; retry_id_i = 9;
    tick();
    done_valid_i = 0; retry_valid_i = 0;
    at_neg();
    check("s6_drop_race", valid_o, 0);
    finish_cycle();
    retry_valid_i = 1; retry_id_i = 20;
    tick();
    retry_valid_i = 0;
    at_neg();
    check("s6_drop_unissued", valid_o, 0);
    check("s6_no_lock", lock_o, 0);
    finish_cycle();

    // Reset during a stalled replay with the lock held.
    reset_dut();
    for (int i = 0; i < 4; i++) push_item(OW'(i % 3));
    ready_i = 0; retry_valid_i = 1; retry_id_i = 2;
    tick();
    retry_valid_i = 0;
    tick();
    valid_i = 1; ready_i = 1; operation_i = 0;
    rst_ni = 0;
    #1;
    check("s7_valid", valid_o, 0);
    check("s7_lock", lock_o, 0);
    check("s7_fault", fault_o, 0);
    check("s7_ready", ready_o, 0);
    valid_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    rst_ni = 1;
    valid_i = 1; ready_i = 1; operation_i = 2; data_i = 32'h1234_5678;
    at_neg();
    check("s7_first_id", id_o, 0);
    finish_cycle();
    valid_i = 0;
    tick();

    // Unconstrained random traffic with retries, completions and faults.
    reset_dut();
    for (int n = 0; n < 600; n++) begin
      valid_i = ($urandom_range(9, 0) < 7);
      ready_i = ($urandom_range(9, 0) < 7);
      operation_i = OW'($urandom_range(2, 0));
      data_i = $urandom;
      retry_valid_i = ($urandom_range(9, 0) < 2);
      retry_id_i = IW'($urandom_range(DEPTH - 1, 0));
      done_valid_i = ($urandom_range(9, 0) < 4);
      done_id_i = IW'($urandom_range(DEPTH - 1, 0));
      tick();
    end
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
